// File: rtl/encap_head.sv
// encap_head: inserts encap units into a tagged head stream at a unit offset.
// Define ENCAP_CNT_EN to add the o_pktCnt / o_insCnt counters.
module encap_head #(
    parameter int HEAD_WIDTH  = 512,
    parameter int SHIFT_WIDTH = 16,
    parameter int TAG_WIDTH   = 8,
    parameter int LEN_WIDTH   = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    output logic                            o_ready,
    input  logic [HEAD_WIDTH-1:0]           i_encapData,
    input  logic [LEN_WIDTH-1:0]            i_encapLen,
    input  logic [LEN_WIDTH-1:0]            i_encapOffset,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic                            o_err
`ifdef ENCAP_CNT_EN
    ,
    output logic [31:0]                     o_pktCnt,
    output logic [31:0]                     o_insCnt
`endif
);
    localparam int HW    = HEAD_WIDTH;
    localparam int UNITS = HEAD_WIDTH / SHIFT_WIDTH;
    localparam int CW    = LEN_WIDTH + 1;
    localparam logic [CW-1:0] UNITS_C = CW'(UNITS);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_FLUSH} state_e;

    // Mask covering the first n units (unit 0 sits at the data MSBs).
    function automatic logic [HW-1:0] hi_mask(input int n);
        return ~({HW{1'b1}} >> (n * SHIFT_WIDTH));
    endfunction

    state_e                  state_q, state_d;
    logic [HW+TAG_WIDTH-1:0] head_q, head_d;
    logic [HW-1:0]           carry_q, carry_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    fld_q, fld_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;

    logic [TAG_WIDTH-1:0] in_tag;
    logic [HW-1:0]        in_data;
    logic                 in_start, in_valid, in_tail;
    logic [LEN_WIDTH-1:0] in_fld, cur_len;
    logic                 accept, take, err_c;
    logic [CW-1:0]        v, tot;
    logic [HW-1:0]        ins_data, body_data, proc_data;
    logic [TAG_WIDTH-1:0] proc_tag;

    assign in_tag   = i_head[HW +: TAG_WIDTH];
    assign in_data  = i_head[HW-1:0];
    assign in_start = in_tag[0];
    assign in_valid = in_tag[1];
    assign in_tail  = in_tag[2];
    assign in_fld   = in_tag[TAG_WIDTH-1:3];

    always_comb begin
        accept  = in_valid & ready_q;
        take    = accept & (in_start | (state_q == S_BODY));
        cur_len = (accept & in_start) ? i_encapLen : len_q;
        v       = {1'b0, in_fld} + CW'(1);
        tot     = v + {1'b0, cur_len};
        err_c   = take & in_start & in_tail & ({1'b0, i_encapOffset} > v);

        ins_data = (in_data & hi_mask(int'(i_encapOffset)))
                 | ((i_encapData & hi_mask(int'(cur_len)))
                    >> (int'(i_encapOffset) * SHIFT_WIDTH))
                 | ((in_data & ~hi_mask(int'(i_encapOffset)))
                    >> (int'(cur_len) * SHIFT_WIDTH));
        body_data = (carry_q & hi_mask(int'(len_q)))
                  | (in_data >> (int'(len_q) * SHIFT_WIDTH));

        proc_data = in_start ? ins_data : body_data;
        proc_tag  = {in_fld, 1'b0, 1'b1, in_start};
        if (in_tail) begin
            if (tot > UNITS_C) begin
                proc_tag = {LEN_WIDTH'(UNITS - 1), 1'b0, 1'b1, in_start};
            end else begin
                proc_tag  = {LEN_WIDTH'(tot - CW'(1)), 1'b1, 1'b1, in_start};
                proc_data = proc_data & hi_mask(int'(tot));
            end
        end

        state_d = state_q;
        head_d  = i_head;
        carry_d = carry_q;
        len_d   = len_q;
        fld_d   = fld_q;
        ready_d = 1'b1;
        err_d   = 1'b0;

        if (state_q == S_FLUSH) begin
            head_d  = {fld_q, 1'b1, 1'b1, 1'b0,
                       carry_q & hi_mask(int'(fld_q) + 1)};
            state_d = S_IDLE;
        end else if (take) begin
            len_d   = cur_len;
            carry_d = in_data << ((UNITS - int'(cur_len)) * SHIFT_WIDTH);
            if (err_c) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else if (cur_len == '0) begin
                state_d = in_tail ? S_IDLE : S_BODY;
            end else begin
                head_d = {proc_tag, proc_data};
                if (!in_tail) begin
                    state_d = S_BODY;
                end else if (tot > UNITS_C) begin
                    // Packet outgrew its last slice: one extra tail follows.
                    state_d = S_FLUSH;
                    ready_d = 1'b0;
                    fld_d   = LEN_WIDTH'(tot - CW'(UNITS + 1));
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            carry_q <= '0;
            len_q   <= '0;
            fld_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            carry_q <= carry_d;
            len_q   <= len_d;
            fld_q   <= fld_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign o_head  = head_q;
    assign o_ready = ready_q;
    assign o_err   = err_q;

`ifdef ENCAP_CNT_EN
    logic        pkt_inc, ins_inc;
    logic [31:0] pkt_cnt_q, ins_cnt_q;

    always_comb begin
        pkt_inc = head_d[HW+1] & head_d[HW+2];
        ins_inc = (state_q == S_FLUSH)
                | (take & ~err_c & in_tail & (cur_len != '0)
                   & (tot <= UNITS_C));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_cnt_q <= '0;
            ins_cnt_q <= '0;
        end else begin
            if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (ins_inc) ins_cnt_q <= ins_cnt_q + 32'd1;
        end
    end

    assign o_pktCnt = pkt_cnt_q;
    assign o_insCnt = ins_cnt_q;
`endif
endmodule
